// File: rtl/lif_param_serializer.sv
// +------------------------------------------------------------------------+
// | Module      : lif_param_serializer                                     |
// | Description : Host-side serial configuration transmitter for the LIF   |
// |               neuron. Shifts a parallel parameter image out MSB-first  |
// |               framed by load_mode, then waits for params_ready.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module lif_param_serializer #(
  parameter int NUM_PARAMS    = 2,
  parameter int PARAM_WIDTH   = 8,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_data,
  input  logic                              params_ready_in,
  output logic                              load_mode,
  output logic                              serial_data,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err
);

  localparam int TOTAL = NUM_PARAMS * PARAM_WIDTH;
  localparam int BCW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int WCW   = $clog2(READY_TIMEOUT + 1);

  localparam logic [BCW-1:0] BIT_CNT_INIT = BCW'(TOTAL - 1);
  localparam logic [WCW-1:0] WAIT_LAST    = WCW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  // Holds the bits still to be presented; because serial_data is registered,
  // the current bit already sits in serial_data and shreg runs one bit ahead.
  logic [TOTAL-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [WCW-1:0]   wait_cnt;

  // Transfer sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Abort on the same cycle as start wins: nothing is accepted.
          if (start && !abort) begin
            serial_data <= param_data[TOTAL-1];
            shreg       <= param_data << 1;
            bit_cnt     <= BIT_CNT_INIT;
            load_mode   <= 1'b1;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (abort) begin
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (bit_cnt == '0) begin
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            state       <= S_GAP;
          end else begin
            serial_data <= shreg[TOTAL-1];
            shreg       <= shreg << 1;
            bit_cnt     <= bit_cnt - 1'b1;
          end
        end

        // One dead cycle so a stale ready from the previous load is ignored.
        S_GAP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end

        // Ready is tested before the timeout so a coincident ack still counts.
        S_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (params_ready_in) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          load_mode   <= 1'b0;
          serial_data <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lif_param_serializer.sv
// +------------------------------------------------------------------------+
// | Module      : tb_lif_param_serializer                                  |
// | Description : Self-checking bench for lif_param_serializer using a     |
// |               timeline reference model of each transfer.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_lif_param_serializer;

  localparam int T         = 16;
  localparam int TO        = 255;
  // Cycle indices relative to the start cycle (t=0).
  localparam int GAP_T     = T + 1;
  localparam int WAIT_T0   = T + 2;
  localparam int WAIT_LAST = WAIT_T0 + TO - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [T-1:0]  param_data;
  logic          params_ready_in;
  logic          load_mode;
  logic          serial_data;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int   n_checks;
  int   n_errors;
  logic prev_err;

  lif_param_serializer #(
    .NUM_PARAMS    (2),
    .PARAM_WIDTH   (8),
    .READY_TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .param_data      (param_data),
    .params_ready_in (params_ready_in),
    .load_mode       (load_mode),
    .serial_data     (serial_data),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {load_mode, serial_data, busy, done, timeout_err};
  endfunction

  // One transfer. rdy_at: cycle from which ready is held high (-1 never).
  // abort_at: cycle carrying a one-cycle abort (-1 none). restart_sel selects
  // a cycle inside the transfer carrying a spurious start (-1 none).
  task automatic do_xfer(input logic [T-1:0] data, input int rdy_at,
                         input int abort_at, input int restart_sel);
    int         rd, last_wait, done_t, idle_t, restart_at;
    bit         aborted, acked;
    logic       exp_err, lm, sd, b, d, e;
    logic [T-1:0] d_local;
    d_local = data;
    // First cycle where an ack can be seen is the first WAIT cycle.
    rd = (rdy_at < 0) ? -1 : ((rdy_at > WAIT_T0) ? rdy_at : WAIT_T0);
    if (rd > WAIT_LAST) rd = -1;
    last_wait  = (rd >= 0) ? rd : WAIT_LAST;
    aborted    = (abort_at >= 1) && (abort_at <= last_wait);
    acked      = !aborted && (rd >= 0);
    done_t     = acked ? rd + 1 : -1;
    idle_t     = aborted ? abort_at + 1 : (acked ? rd + 2 : WAIT_LAST + 1);
    exp_err    = !aborted && !acked;
    restart_at = (restart_sel < 0) ? -1 : (restart_sel % (idle_t - 1)) + 1;

    check("idle_before", {27'd0, outs()}, {27'd0, 4'b0000, prev_err});
    param_data      = data;
    start           = 1'b1;
    abort           = 1'b0;
    params_ready_in = (rdy_at == 0);
    for (int t = 1; t <= idle_t; t++) begin
      @(posedge clk); #1;
      start = (t == restart_at);
      if (start) param_data = ~data;
      abort           = (t == abort_at);
      params_ready_in = (rdy_at >= 0) && (t >= rdy_at);
      lm = (t <= T) && (t < idle_t);
      sd = lm ? d_local[T - t] : 1'b0;
      b  = (t < idle_t);
      d  = (t == done_t);
      e  = (t >= idle_t) ? exp_err : 1'b0;
      check($sformatf("xfer_%h_t%0d", data, t), {27'd0, outs()}, {27'd0, lm, sd, b, d, e});
    end
    start           = 1'b0;
    abort           = 1'b0;
    params_ready_in = 1'b0;
    prev_err        = exp_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    prev_err        = 1'b0;
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    param_data      = '0;
    params_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {27'd0, outs()}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame and ack: ready rises 3 cycles after load_mode falls.
    do_xfer(16'hA55A, GAP_T + 3, -1, -1);
    // Stale ready held high: done must still land at TOTAL+3.
    do_xfer(16'hFF00, 0, -1, -1);
    // Timeout, then a following start clears the flag.
    do_xfer(16'h1234, -1, -1, -1);
    // Spurious start mid-SHIFT (cycle 5) is ignored.
    do_xfer(16'hBEEF, GAP_T + 1, -1, 4);
    // Abort during bit 5.
    do_xfer(16'hC0DE, GAP_T + 1, 5, -1);
    // Set the sticky error again, then collide start and abort in IDLE.
    do_xfer(16'h0F0F, -1, -1, -1);
    param_data = 16'h5555;
    start      = 1'b1;
    abort      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("collide_c%0d", i), {27'd0, outs()}, {27'd0, 4'b0000, 1'b1});
    end
    // Async reset in IDLE clears the sticky error without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("rst_idle_err", {27'd0, outs()}, 32'd0);
    #1;
    reset = 1'b0;
    prev_err = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-frame.
    param_data = 16'hC3C3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst", {27'd0, outs()}, 32'd0);
    @(posedge clk); #1;
    check("rst_held", {27'd0, outs()}, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    do_xfer(16'h0001, GAP_T + 2, -1, -1);

    // Randomized transfers.
    for (int k = 0; k < 24; k++) begin
      int          rdy, ab, rs;
      logic [T-1:0] dat;
      dat = T'($urandom);
      rdy = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
      ab  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 30)) : -1;
      rs  = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, 60)) : -1;
      do_xfer(dat, rdy, ab, rs);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
